// File: rtl/dm_arbiter.sv
// Two-port arbiter sharing the single-port data memory between the CPU (port 0) and an auxiliary master (port 1).
// Optional build macro DMARB_RR_EN: fair round-robin replaces fixed priority plus the MAXWAIT starvation guard.
module dm_arbiter #(
    parameter int unsigned AW      = 7,
    parameter int unsigned DW      = 32,
    parameter int unsigned MAXWAIT = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          m1_starved
);

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

    logic   sel_m0;
    logic   sel_m1;
    logic   s1_rd;
    owner_t s1_owner;

`ifdef DMARB_RR_EN
    owner_t last_owner;

    // On a tie the port that did not win last time is chosen
    always_comb begin
        sel_m0 = m0_req & (~m1_req | (last_owner == OWN_M1));
        sel_m1 = m1_req & ~sel_m0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_owner <= OWN_M1;
        end else if (m0_gnt) begin
            last_owner <= OWN_M0;
        end else if (m1_gnt) begin
            last_owner <= OWN_M1;
        end
    end

    assign m1_starved = 1'b0;
`else
    localparam logic [7:0] MAXW8 = 8'(MAXWAIT);

    logic [7:0] wait_cnt;
    logic       force_m1;

    assign force_m1 = (wait_cnt == MAXW8);

    always_comb begin
        sel_m1 = m1_req & (force_m1 | ~m0_req);
        sel_m0 = m0_req & ~sel_m1;
    end

    // Saturates at MAXWAIT so the force flag stays up until m1 is accepted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt <= '0;
        end else if (!m1_req || m1_gnt) begin
            wait_cnt <= '0;
        end else if (!force_m1) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign m1_starved = force_m1;
`endif

    // Grants are masked while reset is held so nothing is reported as accepted
    assign m0_gnt = sel_m0 & rstn;
    assign m1_gnt = sel_m1 & rstn;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            s1_rd     <= 1'b0;
            s1_owner  <= OWN_M0;
        end else begin
            mem_we <= 1'b0;
            s1_rd  <= 1'b0;
            if (m0_gnt) begin
                mem_addr  <= m0_addr;
                mem_wdata <= m0_wdata;
                mem_we    <= m0_we;
                s1_rd     <= ~m0_we;
                s1_owner  <= OWN_M0;
            end else if (m1_gnt) begin
                mem_addr  <= m1_addr;
                mem_wdata <= m1_wdata;
                mem_we    <= m1_we;
                s1_rd     <= ~m1_we;
                s1_owner  <= OWN_M1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= s1_rd && (s1_owner == OWN_M0);
            m1_rvalid <= s1_rd && (s1_owner == OWN_M1);
            if (s1_rd) begin
                if (s1_owner == OWN_M0) begin
                    m0_rdata <= mem_rdata;
                end else begin
                    m1_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural single-port memory; follows DMARB_RR_EN for the contention section.
module tb_dm_arbiter;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rstn;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          m1_starved;

    logic [DW-1:0] dm_mem [0:(1<<AW)-1];

    int vectors = 0;
    int errors  = 0;

    dm_arbiter #(.AW(AW), .DW(DW), .MAXWAIT(8)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .m1_starved(m1_starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory: synchronous write, combinational read
    always @(posedge clk) if (mem_we) dm_mem[mem_addr] <= mem_wdata;
    assign mem_rdata = dm_mem[mem_addr];

    initial begin
        for (int i = 0; i < (1 << AW); i++) dm_mem[i] <= '0;
        dm_mem[3]  <= 32'h0000_0011;
        dm_mem[4]  <= 32'h0000_0022;
        dm_mem[10] <= 32'hA5A5_0010;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m0_gnt"}, m0_gnt, 0);
        chk({tag, "_m1_gnt"}, m1_gnt, 0);
        chk({tag, "_m0_rvalid"}, m0_rvalid, 0);
        chk({tag, "_m1_rvalid"}, m1_rvalid, 0);
        chk({tag, "_m0_rdata"}, m0_rdata, 0);
        chk({tag, "_m1_rdata"}, m1_rdata, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_starved"}, m1_starved, 0);
    endtask

    initial begin
        logic exp_m1;
        rstn = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        #1 rstn = 1'b0;
        #1 chk_all_zero("por");
        @(negedge clk) rstn = 1'b1;

        // Reset mid-burst: m0 read in flight and m1 just granted when reset hits
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_addr = 7'd10;
        m1_req = 1; m1_we = 0; m1_addr = 7'd3;
        #1 chk("burst_m0_gnt", m0_gnt, 1);
        chk("burst_m1_gnt", m1_gnt, 0);
        @(negedge clk);
        m0_req = 0;
        #1 chk("burst_mem_addr", 32'(mem_addr), 10);
        chk("burst_m1_gnt2", m1_gnt, 1);
        rstn = 1'b0;
        m1_req = 0;
        #1 chk_all_zero("midrst");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1 chk("rst_m0_rvalid", m0_rvalid, 0);
            chk("rst_m1_rvalid", m1_rvalid, 0);
        end
        @(negedge clk) rstn = 1'b1;
        @(negedge clk);
        #1 chk("idle_mem_we", mem_we, 0);
        chk("idle_m0_rvalid", m0_rvalid, 0);
        chk("idle_m1_rvalid", m1_rvalid, 0);

        // m0 write then read of addr 5
        @(negedge clk);
        m0_req = 1; m0_we = 1; m0_addr = 7'd5; m0_wdata = 32'hDEAD_BEEF;
        #1 chk("wr_m0_gnt", m0_gnt, 1);
        chk("wr_t1_mem_we", mem_we, 0);
        @(negedge clk);
        m0_we = 0;
        #1 chk("rd_m0_gnt", m0_gnt, 1);
        chk("wr_t2_mem_we", mem_we, 1);
        chk("wr_t2_mem_addr", 32'(mem_addr), 5);
        chk("wr_t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        m0_req = 0;
        #1 chk("t3_mem_we", mem_we, 0);
        chk("t3_mem_addr", 32'(mem_addr), 5);
        chk("t3_m0_rvalid", m0_rvalid, 0);
        @(negedge clk);
        #1 chk("t4_m0_rvalid", m0_rvalid, 1);
        chk("t4_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("t4_mem_we", mem_we, 0);
        chk("t4_mem_addr_hold", 32'(mem_addr), 5);
        @(negedge clk);
        #1 chk("t5_m0_rvalid", m0_rvalid, 0);
        chk("t5_m0_rdata_hold", m0_rdata, 32'hDEAD_BEEF);

        // Mixed back-to-back reads: m1 addr 3 then m0 addr 4
        @(negedge clk);
        m1_req = 1; m1_we = 0; m1_addr = 7'd3;
        #1 chk("mix_m1_gnt", m1_gnt, 1);
        chk("mix_m0_gnt", m0_gnt, 0);
        @(negedge clk);
        m1_req = 0;
        m0_req = 1; m0_we = 0; m0_addr = 7'd4;
        #1 chk("mix_m0_gnt2", m0_gnt, 1);
        chk("mix_m1_gnt2", m1_gnt, 0);
        @(negedge clk);
        m0_req = 0;
        #1 chk("mix_t2_m1_rvalid", m1_rvalid, 1);
        chk("mix_t2_m1_rdata", m1_rdata, 32'h11);
        chk("mix_t2_m0_rvalid", m0_rvalid, 0);
        chk("mix_t2_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        #1 chk("mix_t3_m0_rvalid", m0_rvalid, 1);
        chk("mix_t3_m0_rdata", m0_rdata, 32'h22);
        chk("mix_t3_m1_rvalid", m1_rvalid, 0);
        chk("mix_t3_m1_rdata", m1_rdata, 32'h11);
        @(negedge clk);
        #1 chk("mix_t4_m0_rvalid", m0_rvalid, 0);
        chk("mix_t4_m1_rvalid", m1_rvalid, 0);
        chk("mix_t4_m0_rdata", m0_rdata, 32'h22);
        chk("mix_t4_m1_rdata", m1_rdata, 32'h11);

        // Contention from a fresh reset; requests raised in the first cycle out of reset
        @(negedge clk) rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        m0_req = 1; m0_we = 0; m0_addr = 7'd4;
        m1_req = 1; m1_we = 0; m1_addr = 7'd3;
`ifdef DMARB_RR_EN
        for (int k = 1; k <= 8; k++) begin
            exp_m1 = (k % 2 == 0);
            #1 chk("rr_m0_gnt", m0_gnt, !exp_m1);
            chk("rr_m1_gnt", m1_gnt, exp_m1);
            chk("rr_starved", m1_starved, 0);
            @(negedge clk);
        end
`else
        for (int k = 1; k <= 18; k++) begin
            exp_m1 = (k % 9 == 0);
            #1 chk("cont_m0_gnt", m0_gnt, !exp_m1);
            chk("cont_m1_gnt", m1_gnt, exp_m1);
            chk("cont_starved", m1_starved, exp_m1);
            @(negedge clk);
        end
`endif
        m0_req = 0; m1_req = 0;
        #1 chk("end_starved", m1_starved, 0);
        repeat (3) @(negedge clk);
        #1 chk("end_m0_rvalid", m0_rvalid, 0);
        chk("end_m1_rvalid", m1_rvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter that shares the single-port data memory (`dm`) between the CPU data port (port 0) and an auxiliary master (port 1: program loader / debug / DMA). It sits between `SCPU`'s data bus and `U_DM` in `sccomp`. It accepts at most one transaction per cycle, registers it onto the memory bus, and returns read data with a fixed latency. Port 0 has fixed priority, and a wait counter bounds how long port 1 can starve.

## Interface
- `AW`, 7, word-address width (matches `dm` addr[8:2])
- `DW`, 32, data width
- `MAXWAIT`, 8, cycles port 1 may wait with `m1_req` high before it is force-granted (1..255)
- `clk`  in  1  system clock, rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `m0_req`, `m1_req`  in  1  transaction request (level, held until granted)
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read; qualified by req
- `m0_addr`, `m1_addr`  in  AW  word address
- `m0_wdata`, `m1_wdata`  in  DW  write data
- `m0_gnt`, `m1_gnt`  out  1  combinational grant; req&gnt = accepted this cycle
- `m0_rvalid`, `m1_rvalid`  out  1  one-cycle read-data-valid pulse
- `m0_rdata`, `m1_rdata`  out  DW  read data, valid with rvalid, held otherwise
- `mem_we`  out  1  to `dm` DMWr
- `mem_addr`  out  AW  to `dm` addr
- `mem_wdata`  out  DW  to `dm` din
- `mem_rdata`  in  DW  from `dm` dout (combinational read)
- `m1_starved`  out  1  high while the force-grant is active

## Operation
- Grant rules (default build): if `m1` force flag is set and `m1_req` is high, grant m1. Otherwise grant m0 if `m0_req` is high. Otherwise grant m1 if `m1_req` is high. At most one gnt is high per cycle, and gnt is never high without its req.
- Wait counter (8-bit): increments each cycle `m1_req`=1 and m1 is not granted, saturating at MAXWAIT. It clears on m1 acceptance or when `m1_req`=0. Force flag = (count == MAXWAIT). `m1_starved` = force flag.
- Pipeline stage S1 (cycle after accept): registered `mem_addr`/`mem_wdata`, `mem_we` = 1 only for an accepted write, and a registered owner ID plus read flag.
- Stage S2: for a read, `mem_rdata` sampled at the end of S1 is registered into the owner's rdata, and the owner's rvalid pulses for one cycle. The other port's rdata is unchanged.
- Writes produce no rvalid.
- Idle cycles: `mem_we`=0; `mem_addr`/`mem_wdata` hold their last values.

## Timing
- Accept at cycle T. Memory is driven in T+1, where a write commits at the rising edge ending T+1. Read data appears with rvalid in T+2.
- Throughput is one transaction per cycle, back-to-back, with no bubbles. Two masters may each complete a read in consecutive cycles.
- A write accepted at T, followed by a read of the same address accepted at T+1, returns the new data.
- Reset (async assert, any time): all outputs go to 0, the counter and force flag clear, and the pipeline flushes. In-flight reads never produce rvalid, and an in-flight write is dropped if reset asserts before its commit edge.
- Deassertion: the first accept can occur in the first cycle with `rstn`=1.
- Simultaneous requests: rules above, decided entirely within the same cycle.
- Counter saturation: the counter stays at MAXWAIT until m1 is granted. It is never exceeded and never wraps.

## Configuration
- `DMARB_RR_EN` defined: fair round-robin replaces priority plus counter.
  - A 1-bit last-owner register is reset to 1, so m0 wins the first tie.
  - On simultaneous requests, the port not granted last wins. A single requester is always granted.
  - The counter is removed and `m1_starved` is tied to 0.
- Not defined: fixed priority with the MAXWAIT starvation guard, as described above.

## Test plan
- Reset/idle: hold `rstn`=0 mid-burst, then release. Required: all outputs 0, no rvalid from flushed reads, and `mem_we`=0 on the first idle cycle.
- Single-port read latency: m0 writes 0xDEADBEEF to addr 5 at T=1 and reads addr 5 at T=2. Required: `mem_we`=1 only in T=2, and `m0_rvalid`=1 with `m0_rdata`=0xDEADBEEF in T=4.
- Contention (default build): m0_req and m1_req both held high continuously with MAXWAIT=8. Required:
  - m0 is granted for 8 cycles;
  - m1 is granted on the 9th cycle with `m1_starved`=1;
  - the pattern then repeats.
- Round-robin (`DMARB_RR_EN`): both requests held high continuously. Required: grants alternate m0, m1, m0, ..., and `m1_starved` stays 0.
- Mixed back-to-back: m1 reads addr 3 (value 0x11) at T, and m0 reads addr 4 (value 0x22) at T+1. Required:
  - `m1_rvalid` in T+2 with data 0x11;
  - `m0_rvalid` in T+3 with data 0x22;
  - each port's rdata is otherwise unchanged.
